// File: rtl/sprite_mover.sv
// Grid sprite controller: resolves direction requests and auto-repeats held directions on a tick timebase.
// Refused edge steps are clamped (bump) or wrapped, depending on WRAP.
module sprite_mover #(
   parameter int GRID_W  = 16,
   parameter int GRID_H  = 12,
   parameter int CW      = 4,
   parameter int START_X = 4,
   parameter int START_Y = 4,
   parameter int DELAY   = 8,
   parameter int RATE    = 4,
   parameter int WRAP    = 0,
   parameter int NW      = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tick,
   input  logic          move_up,
   input  logic          move_down,
   input  logic          move_left,
   input  logic          move_right,
   input  logic          respawn,
   output logic [CW-1:0] player_x,
   output logic [CW-1:0] player_y,
   output logic          step,
   output logic          bump,
   output logic [NW-1:0] move_count
);

   localparam int MAXC = (DELAY > RATE) ? DELAY : RATE;
   localparam int CTW  = $clog2(MAXC + 1);

   localparam logic [CW-1:0]  X_MAX   = CW'(GRID_W - 1);
   localparam logic [CW-1:0]  Y_MAX   = CW'(GRID_H - 1);
   localparam logic [CW-1:0]  X_START = CW'(START_X);
   localparam logic [CW-1:0]  Y_START = CW'(START_Y);
   localparam logic [CTW-1:0] C_DELAY = CTW'(DELAY);
   localparam logic [CTW-1:0] C_RATE  = CTW'(RATE);
   localparam logic [CTW-1:0] C_ONE   = CTW'(1);

   typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
   typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

   state_t         state, next_state;
   dir_t           dir_q, next_dir, req;
   logic [CTW-1:0] cnt, next_cnt;
   logic           attempt;
   logic           hit_edge;
   logic           move_ok;
   logic           bump_d;
   logic [CW-1:0]  nx, ny;

   // Opposing requests cancel; the vertical axis wins over the horizontal one.
   always_comb begin
      req = DIR_NONE;
      if (move_up && !move_down)
         req = DIR_UP;
      else if (move_down && !move_up)
         req = DIR_DOWN;
      else if (move_left && !move_right)
         req = DIR_LEFT;
      else if (move_right && !move_left)
         req = DIR_RIGHT;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         dir_q <= DIR_NONE;
         cnt   <= '0;
      end else begin
         state <= next_state;
         dir_q <= next_dir;
         cnt   <= next_cnt;
      end
   end

   always_comb begin
      next_state = state;
      next_dir   = dir_q;
      next_cnt   = cnt;
      if (respawn || req == DIR_NONE) begin
         next_state = IDLE;
         next_dir   = DIR_NONE;
         next_cnt   = '0;
      end else if (state == IDLE || req != dir_q) begin
         next_state = HOLD;
         next_dir   = req;
         next_cnt   = C_DELAY;
      end else if (tick) begin
         if (cnt == C_ONE) begin
            next_state = REPEAT;
            next_cnt   = C_RATE;
         end else begin
            next_cnt = cnt - C_ONE;
         end
      end
   end

   // A step is attempted on every fresh press and whenever the repeat counter expires on a tick.
   always_comb begin
      attempt = 1'b0;
      if (!respawn && req != DIR_NONE)
         attempt = (state == IDLE) || (req != dir_q) || (tick && cnt == C_ONE);
   end

   // Candidate position; hit_edge marks a move that leaves the grid, in which case nx/ny hold the wrapped cell.
   always_comb begin
      nx       = player_x;
      ny       = player_y;
      hit_edge = 1'b0;
      case (req)
         DIR_UP: begin
            hit_edge = (player_y == '0);
            ny       = hit_edge ? Y_MAX : player_y - 1'b1;
         end
         DIR_DOWN: begin
            hit_edge = (player_y == Y_MAX);
            ny       = hit_edge ? '0 : player_y + 1'b1;
         end
         DIR_LEFT: begin
            hit_edge = (player_x == '0);
            nx       = hit_edge ? X_MAX : player_x - 1'b1;
         end
         DIR_RIGHT: begin
            hit_edge = (player_x == X_MAX);
            nx       = hit_edge ? '0 : player_x + 1'b1;
         end
         default: begin
            nx       = player_x;
            ny       = player_y;
            hit_edge = 1'b0;
         end
      endcase
      move_ok = attempt && (!hit_edge || WRAP != 0);
      bump_d  = attempt && hit_edge && (WRAP == 0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         player_x   <= X_START;
         player_y   <= Y_START;
         move_count <= '0;
         step       <= 1'b0;
         bump       <= 1'b0;
      end else if (respawn) begin
         player_x   <= X_START;
         player_y   <= Y_START;
         move_count <= '0;
         step       <= 1'b0;
         bump       <= 1'b0;
      end else begin
         step <= move_ok;
         bump <= bump_d;
         if (move_ok) begin
            player_x <= nx;
            player_y <= ny;
            if (move_count != '1)
               move_count <= move_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sprite_mover.sv
// Bench for sprite_mover: one clamping and one wrapping instance share stimulus and are checked
// every cycle against a press/elapsed-tick model of the movement rules.
module tb_sprite_mover;

   localparam int GW = 16;
   localparam int GH = 12;
   localparam int SX = 4;
   localparam int SY = 4;
   localparam int DL = 8;
   localparam int RT = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tick = 1'b0;
   logic move_up = 1'b0, move_down = 1'b0, move_left = 1'b0, move_right = 1'b0;
   logic respawn = 1'b0;

   logic [3:0]  x_c, y_c, x_w, y_w;
   logic        step_c, bump_c, step_w, bump_w;
   logic [15:0] count_c;
   logic [2:0]  count_w;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int x;
      int y;
      int count;
      bit step;
      bit bump;
      bit active;
      int held;
      int ticks;
   } model_t;

   model_t mc, mw;

   always #5 clk = ~clk;

   sprite_mover #(.WRAP(0), .NW(16)) dut_c (
      .clk(clk), .rst(rst), .tick(tick),
      .move_up(move_up), .move_down(move_down), .move_left(move_left), .move_right(move_right),
      .respawn(respawn), .player_x(x_c), .player_y(y_c), .step(step_c), .bump(bump_c),
      .move_count(count_c)
   );

   sprite_mover #(.WRAP(1), .NW(3)) dut_w (
      .clk(clk), .rst(rst), .tick(tick),
      .move_up(move_up), .move_down(move_down), .move_left(move_left), .move_right(move_right),
      .respawn(respawn), .player_x(x_w), .player_y(y_w), .step(step_w), .bump(bump_w),
      .move_count(count_w)
   );

   function automatic model_t model_reset();
      model_t m;
      m.x = SX; m.y = SY; m.count = 0; m.step = 0; m.bump = 0;
      m.active = 0; m.held = 0; m.ticks = 0;
      return m;
   endfunction

   // 0 none, 1 up, 2 down, 3 left, 4 right
   function automatic int resolve(bit u, bit d, bit l, bit r);
      if (u && !d) return 1;
      if (d && !u) return 2;
      if (l && !r) return 3;
      if (r && !l) return 4;
      return 0;
   endfunction

   // Steps fall on the press and whenever elapsed ticks = DELAY + k*RATE.
   function automatic model_t model_next(model_t m, bit wrap, int cmax,
                                         bit u, bit d, bit l, bit r, bit tk, bit rs);
      model_t n;
      int dir, tx, ty;
      bit go;
      n = m;
      n.step = 0;
      n.bump = 0;
      go = 0;
      dir = resolve(u, d, l, r);
      if (rs) return model_reset();
      if (dir == 0) begin
         n.active = 0;
      end else if (!m.active || dir != m.held) begin
         go = 1; n.active = 1; n.held = dir; n.ticks = 0;
      end else if (tk) begin
         n.ticks = m.ticks + 1;
         if (n.ticks >= DL && (n.ticks - DL) % RT == 0) go = 1;
      end
      if (go) begin
         tx = m.x + ((dir == 4) ? 1 : (dir == 3) ? -1 : 0);
         ty = m.y + ((dir == 2) ? 1 : (dir == 1) ? -1 : 0);
         if ((tx >= 0 && tx < GW && ty >= 0 && ty < GH) || wrap) begin
            n.x = (tx + GW) % GW;
            n.y = (ty + GH) % GH;
            n.step = 1;
            if (m.count < cmax) n.count = m.count + 1;
         end else begin
            n.bump = 1;
         end
      end
      return n;
   endfunction

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      check_output("clamp_x", 32'(x_c), 32'(mc.x));
      check_output("clamp_y", 32'(y_c), 32'(mc.y));
      check_output("clamp_count", 32'(count_c), 32'(mc.count));
      check_output("clamp_step", 32'(step_c), 32'(mc.step));
      check_output("clamp_bump", 32'(bump_c), 32'(mc.bump));
      check_output("wrap_x", 32'(x_w), 32'(mw.x));
      check_output("wrap_y", 32'(y_w), 32'(mw.y));
      check_output("wrap_count", 32'(count_w), 32'(mw.count));
      check_output("wrap_step", 32'(step_w), 32'(mw.step));
      check_output("wrap_bump", 32'(bump_w), 32'(mw.bump));
   endtask

   // Drive one cycle of inputs, advance both models at the edge, compare just after it.
   task automatic apply_stimulus(input bit u, input bit d, input bit l, input bit r,
                                 input bit tk, input bit rs);
      move_up = u; move_down = d; move_left = l; move_right = r;
      tick = tk; respawn = rs;
      @(posedge clk);
      mc = model_next(mc, 1'b0, 65535, u, d, l, r, tk, rs);
      mw = model_next(mw, 1'b1, 7, u, d, l, r, tk, rs);
      #1;
      compare_all();
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 0, 1, 0);
   endtask

   initial begin
      mc = model_reset();
      mw = model_reset();
      #12;
      check_output("reset_x", 32'(x_c), 32'(SX));
      check_output("reset_y", 32'(y_c), 32'(SY));
      check_output("reset_count", 32'(count_c), 32'd0);
      check_output("reset_step", 32'(step_c), 32'd0);
      rst = 1'b0;
      #4;

      // single press to the right
      apply_stimulus(0, 0, 0, 1, 0, 0);
      check_output("press_x", 32'(x_c), 32'd5);
      check_output("press_step", 32'(step_c), 32'd1);
      check_output("press_count", 32'(count_c), 32'd1);
      idle_cycles(3);
      check_output("press_no_more", 32'(count_c), 32'd1);

      // walk to the corner (0,0) with discrete taps
      for (int i = 0; i < 5; i++) begin
         apply_stimulus(0, 0, 1, 0, 0, 0);
         idle_cycles(1);
      end
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(1, 0, 0, 0, 0, 0);
         idle_cycles(1);
      end
      check_output("corner_x", 32'(x_c), 32'd0);
      check_output("corner_y", 32'(y_c), 32'd0);
      apply_stimulus(0, 0, 1, 0, 0, 0);
      check_output("clamp_left_bump", 32'(bump_c), 32'd1);
      check_output("clamp_left_x", 32'(x_c), 32'd0);
      check_output("wrap_left_x", 32'(x_w), 32'd15);
      check_output("wrap_left_step", 32'(step_w), 32'd1);
      apply_stimulus(1, 0, 0, 0, 0, 0);
      check_output("clamp_up_bump", 32'(bump_c), 32'd1);
      check_output("wrap_up_y", 32'(y_w), 32'd11);
      idle_cycles(1);

      // respawn back to the spawn cell
      apply_stimulus(0, 0, 0, 0, 0, 1);
      check_output("respawn_x", 32'(x_c), 32'(SX));
      check_output("respawn_y", 32'(y_c), 32'(SY));
      check_output("respawn_count", 32'(count_c), 32'd0);

      // auto-repeat: down held 20 cycles, tick every cycle
      for (int i = 0; i < 20; i++) apply_stimulus(0, 1, 0, 0, 1, 0);
      idle_cycles(1);
      check_output("repeat_y", 32'(y_c), 32'd8);
      check_output("repeat_count", 32'(count_c), 32'd4);

      // conflict and priority
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1, 1, 0, 0, 1, 0);
         check_output("conflict_step", 32'(step_c), 32'd0);
      end
      idle_cycles(1);
      apply_stimulus(1, 0, 0, 1, 0, 0);
      check_output("prio_y", 32'(y_c), 32'd7);
      check_output("prio_x", 32'(x_c), 32'd4);
      idle_cycles(1);

      // direction change mid-hold restarts DELAY
      for (int i = 0; i < 6; i++) apply_stimulus(0, 0, 0, 1, 1, 0);
      for (int i = 0; i < 12; i++) apply_stimulus(1, 0, 0, 0, 1, 0);
      idle_cycles(1);

      // respawn with a held direction, then the hold resumes as a fresh press
      for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 1, 0, 1, 0);
      for (int i = 0; i < 2; i++) apply_stimulus(0, 0, 1, 0, 1, 1);
      for (int i = 0; i < 10; i++) apply_stimulus(0, 0, 1, 0, 1, 0);

      // async reset between edges while still holding left
      #2;
      rst = 1'b1;
      #1;
      mc = model_reset();
      mw = model_reset();
      check_output("async_x", 32'(x_c), 32'(SX));
      check_output("async_y", 32'(y_c), 32'(SY));
      check_output("async_count", 32'(count_c), 32'd0);
      check_output("async_step", 32'(step_c), 32'd0);
      #1;
      rst = 1'b0;
      @(posedge clk);
      mc = model_next(mc, 1'b0, 65535, 0, 0, 1, 0, 1, 0);
      mw = model_next(mw, 1'b1, 7, 0, 0, 1, 0, 1, 0);
      #1;
      compare_all();
      check_output("after_reset_step", 32'(step_c), 32'd1);

      // randomized holds of random length with an irregular tick
      for (int seg = 0; seg < 250; seg++) begin
         logic [3:0] dirs;
         int len;
         bit rs;
         dirs = 4'($urandom);
         if ($urandom_range(0, 1) == 0) dirs = 4'(1 << $urandom_range(0, 3));
         len = $urandom_range(1, 25);
         for (int i = 0; i < len; i++) begin
            rs = ($urandom_range(0, 63) == 0);
            apply_stimulus(dirs[0], dirs[1], dirs[2], dirs[3], $urandom_range(0, 2) != 0, rs);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sprite_mover.md
SPRITE_MOVER -- requirements
Module: sprite_mover

Interface
REQ-001 Parameter GRID_W, default 16: number of columns; legal x is 0..GRID_W-1.
REQ-002 Parameter GRID_H, default 12: number of rows; legal y is 0..GRID_H-1.
REQ-003 Parameter CW, default 4: coordinate width; GRID_W and GRID_H SHALL each be <= 2^CW.
REQ-004 Parameter START_X, default 4 / START_Y, default 4: spawn cell; SHALL lie inside the grid.
REQ-005 Parameter DELAY, default 8 (>=1): ticks from the first step of a held direction to the first auto-repeat step.
REQ-006 Parameter RATE, default 4 (>=1): ticks between later auto-repeat steps.
REQ-007 Parameter WRAP, default 0: 0 = clamp at the grid edge; 1 = wrap to the opposite edge.
REQ-008 Parameter NW, default 16: width of move_count.
REQ-009 clk  in  1  single system clock; every register is clocked on its rising edge.
REQ-010 rst  in  1  asynchronous, active-high reset.
REQ-011 tick  in  1  one-cycle timebase strobe; the repeat counters advance only on cycles where tick=1.
REQ-012 move_up, move_down, move_left, move_right  in  1 each  level-sensitive direction requests.
REQ-013 respawn  in  1  synchronous return to the spawn cell.
REQ-014 player_x  out  CW  current column (registered).
REQ-015 player_y  out  CW  current row (registered).
REQ-016 step  out  1  one-cycle pulse in the cycle after a coordinate changes.
REQ-017 bump  out  1  one-cycle pulse in the cycle after a step is refused at an edge (WRAP=0 only).
REQ-018 move_count  out  NW  number of successful steps since reset or respawn; saturates at all-ones.

Function
REQ-019 The direction request SHALL resolve each cycle as follows: up&!down gives UP; otherwise down&!up gives DOWN; otherwise left&!right gives LEFT; otherwise right&!left gives RIGHT; otherwise NONE. Opposing pairs cancel, and the vertical axis has priority over the horizontal axis.
REQ-020 The state machine SHALL have three states: IDLE, HOLD and REPEAT. It SHALL also hold a latched direction register and a repeat counter at least as wide as max(DELAY,RATE).
REQ-021 IDLE: when the request is not NONE, the block SHALL attempt one step in that direction, latch the direction, load the counter with DELAY and enter HOLD. This happens on the next edge and does not depend on tick.
REQ-022 HOLD or REPEAT, request NONE: the block SHALL go to IDLE with no step.
REQ-023 HOLD or REPEAT, request differs from the latched direction and is not NONE: the block SHALL treat it as a new press. It attempts a step, latches the new direction, loads DELAY and enters HOLD.
REQ-024 HOLD or REPEAT, request equals the latched direction, tick=1: if the counter equals 1, the block SHALL attempt a step, load RATE and enter or stay in REPEAT. Otherwise it SHALL decrement the counter.
REQ-025 If tick=0 and the request is unchanged, the counter and state SHALL hold.
REQ-026 A step attempt SHALL change exactly one coordinate by +/-1: UP gives y-1, DOWN gives y+1, LEFT gives x-1, RIGHT gives x+1.
REQ-027 Edge rule, WRAP=0: a step from y=0 up, y=GRID_H-1 down, x=0 left or x=GRID_W-1 right SHALL leave the position unchanged and pulse bump. The state machine SHALL advance as if the step had succeeded.
REQ-028 Edge rule, WRAP=1: the same four moves SHALL wrap to GRID_H-1, 0, GRID_W-1 and 0 respectively, and SHALL count as successful steps. bump SHALL never assert.
REQ-029 Every successful step SHALL pulse step and increment move_count, which saturates at all-ones.
REQ-030 step and bump SHALL be mutually exclusive, and each SHALL be high for exactly one cycle per attempt.
REQ-031 respawn=1 SHALL take priority over all movement. On the next edge it SHALL set player_x=START_X, player_y=START_Y, move_count=0 and state IDLE, with step and bump low.
REQ-032 A direction held through respawn SHALL be handled from IDLE in the first cycle after respawn deasserts, as a new press.

Reset
REQ-033 While rst=1 the block SHALL immediately set player_x=START_X, player_y=START_Y, move_count=0, step=0, bump=0, state IDLE, latched direction NONE and counter 0, without waiting for a clock edge.
REQ-034 Reset applied mid-HOLD or mid-REPEAT SHALL abandon the pending repeat. After rst deasserts, a still-held direction SHALL produce a step as a fresh press.

Verification
REQ-035 Single press: defaults, move_right high for 1 cycle -> player_x 4->5 one cycle later, step pulses once, move_count=1, no further steps.
REQ-036 Auto-repeat: DELAY=8, RATE=4, tick every cycle, move_down held 20 cycles from y=4 -> steps at press+1, +9, +13 and +17, giving y=8 and move_count=4.
REQ-037 Clamp vs wrap: start (0,0), pulse move_left. With WRAP=0, x stays 0, bump=1 and move_count=0. With WRAP=1, x=15, step=1 and move_count=1.
REQ-038 Conflict and priority: move_up and move_down both high -> no step. Then up and right both high -> only y decrements.
REQ-039 Direction change mid-hold: hold right for 5 ticks, then switch to up -> up step happens on the next edge and DELAY restarts from full.
REQ-040 Respawn and async reset: respawn pulsed at (9,2) with count 7 -> (4,4) and count 0. rst asserted between clock edges -> outputs reach reset values before the next edge.
